// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath definitions.
//  - Funct3 load/store width encodings
//  - data-memory responder FSM state encoding
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data-memory responder.
// Ports:
//   funct3    in   access width / extension select
//   is_store  in   1 = store (only b/h/w are legal), 0 = load
//   addr_lo   in   byte offset within the word
//   wdata     in   store data, LSB-aligned
//   rword     in   raw 32-bit word read from storage
//   byte_en   out  lanes to write (zero when misaligned/illegal)
//   wdata_sh  out  store data shifted onto its lanes
//   rdata_ext out  load data shifted down and sign/zero extended
//   misalign  out  misaligned address or illegal funct3 for this op
module dmem_lane_align
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic        is_store,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata_ext,
   output logic        misalign
);

   logic [4:0]  shamt;
   logic [31:0] rshift;

   always_comb begin
      shamt     = {addr_lo, 3'b000};
      rshift    = rword >> shamt;
      wdata_sh  = wdata << shamt;
      byte_en   = 4'b0000;
      rdata_ext = rshift;
      misalign  = 1'b0;
      case (funct3)
         F3_B: begin
            byte_en   = 4'b0001 << addr_lo;
            rdata_ext = {{24{rshift[7]}}, rshift[7:0]};
         end
         F3_BU: begin
            misalign  = is_store;
            rdata_ext = {24'b0, rshift[7:0]};
         end
         F3_H: begin
            misalign  = addr_lo[0];
            byte_en   = 4'b0011 << addr_lo;
            rdata_ext = {{16{rshift[15]}}, rshift[15:0]};
         end
         F3_HU: begin
            misalign  = addr_lo[0] | is_store;
            rdata_ext = {16'b0, rshift[15:0]};
         end
         F3_W: begin
            misalign  = |addr_lo;
            byte_en   = 4'b1111;
         end
         default: misalign = 1'b1;
      endcase
      if (misalign) byte_en = 4'b0000;
   end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts a MemRead/MemWrite request in
// IDLE, waits WAIT_CYCLES, then completes with a one-cycle Ready pulse.
// Optional macro DMEM_FAST_READ_EN: loads skip the WAIT state (1-cycle latency).
// Ports:
//   clk, rst_n          clock / async active-low reset
//   MemRead, MemWrite   request, held until Ready (both high = store)
//   Addr, WriteData     byte address, store data
//   Funct3              access width / extension
//   ReadData            extended load data, held until the next good load
//   Ready               completion pulse
//   Busy                high while waiting out the wait states
//   MisalignErr         qualifies Ready: access rejected
module data_mem_responder
   import riscv_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   input  logic [2:0]  Funct3,
   output logic [31:0] ReadData,
   output logic        Ready,
   output logic        Busy,
   output logic        MisalignErr
);

   localparam int         DEPTH    = 2 ** ADDR_W;
   // WAIT lasts WAIT_CYCLES cycles: counter expires after reaching zero
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   dmem_state_e         state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W+1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [2:0]          f3_q, f3_d;
   logic                store_q, store_d;
   logic [31:0]         rdata_q, rdata_d;

   logic [31:0]         mem [DEPTH];
   logic [31:0]         rword;
   logic [3:0]          byte_en;
   logic [31:0]         wdata_sh;
   logic [31:0]         rdata_ext;
   logic                misalign;
   logic                resp;

   // upper address bits alias onto the array
   logic                unused_addr;
   assign unused_addr = ^Addr[31:ADDR_W+2];

   assign rword = mem[addr_q[ADDR_W+1:2]];
   assign resp  = (state_q == ST_RESP);

   dmem_lane_align u_align (
      .funct3    (f3_q),
      .is_store  (store_q),
      .addr_lo   (addr_q[1:0]),
      .wdata     (wdata_q),
      .rword     (rword),
      .byte_en   (byte_en),
      .wdata_sh  (wdata_sh),
      .rdata_ext (rdata_ext),
      .misalign  (misalign)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      store_d = store_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (MemRead | MemWrite) begin
               addr_d  = Addr[ADDR_W+1:0];
               wdata_d = WriteData;
               f3_d    = Funct3;
               store_d = MemWrite;
               cnt_d   = CNT_INIT;
               state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
`ifdef DMEM_FAST_READ_EN
               if (!MemWrite) state_d = ST_RESP;
`endif
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            if (!store_q && !misalign) rdata_d = rdata_ext;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         f3_q    <= 3'd0;
         store_q <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         store_q <= store_d;
         rdata_q <= rdata_d;
      end
   end

   // storage is not reset; a store only lands on the RESP edge, so a reset
   // during WAIT discards it
   always_ff @(posedge clk) begin
      if (resp && store_q && !misalign) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[addr_q[ADDR_W+1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
         end
      end
   end

   // load data is presented in the RESP cycle itself, then held in rdata_q
   assign ReadData    = (resp && !store_q && !misalign) ? rdata_ext : rdata_q;
   assign Ready       = resp;
   assign MisalignErr = resp & misalign;
   assign Busy        = (state_q == ST_WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

   localparam int ADDR_W      = 8;
   localparam int WAIT_CYCLES = 2;
   localparam int DEPTH       = 2 ** ADDR_W;
   localparam int NWORDS      = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        MemRead = 1'b0, MemWrite = 1'b0;
   logic [31:0] Addr = 32'd0, WriteData = 32'd0;
   logic [2:0]  Funct3 = 3'd0;
   logic [31:0] ReadData;
   logic        Ready, Busy, MisalignErr;

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
      .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
      .Addr(Addr), .WriteData(WriteData), .Funct3(Funct3),
      .ReadData(ReadData), .Ready(Ready), .Busy(Busy), .MisalignErr(MisalignErr)
   );

   int checks = 0, failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          issue;
      int          lat;
      string       name;
   } exp_t;
   exp_t q[$];

   // reference model: byte-addressed word array + last good load value
   logic [7:0]  mm [DEPTH][4];
   logic [31:0] last_rd = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic model_req(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [2:0] f3, output exp_t e);
      int w, off, size;
      bit legal, err;
      logic [31:0] val;
      w    = int'((a >> 2) % DEPTH);
      off  = int'(a[1:0]);
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if (wr) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
      else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      err = !legal || (off % size) != 0;
      if (!err && wr) begin
         for (int k = 0; k < size; k++) mm[w][off+k] = wd[8*k +: 8];
      end else if (!err) begin
         val = 32'd0;
         for (int k = 0; k < size; k++) val[8*k +: 8] = mm[w][off+k];
         if (!f3[2] && size == 1 && val[7])  val = val | 32'hFFFF_FF00;
         if (!f3[2] && size == 2 && val[15]) val = val | 32'hFFFF_0000;
         last_rd = val;
      end
      e.rdata = last_rd;
      e.err   = err;
      e.lat   = WAIT_CYCLES;
`ifdef DMEM_FAST_READ_EN
      if (!wr) e.lat = 0;
`endif
   endtask

   task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3, input string name);
      exp_t e;
      bit got;
      model_req(wr, a, wd, f3, e);
      e.name = name;
      @(negedge clk);
      MemRead = rd; MemWrite = wr; Addr = a; WriteData = wd; Funct3 = f3;
      e.issue = cyc + 1;
      q.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         got = Ready;
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL %s_timeout actual=no_ready required=ready", name);
         void'(q.pop_back());
      end
      MemRead = 1'b0; MemWrite = 1'b0;
   endtask

   // monitor: pops one expectation per Ready pulse
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (Ready) begin
            if (q.size() == 0) begin
               checks++; failures++;
               $display("FAIL spurious_ready actual=1 required=0");
            end else begin
               e = q.pop_front();
               chk({e.name, "_latency"}, 32'(cyc - e.issue), 32'(e.lat));
               chk({e.name, "_err"}, {31'd0, MisalignErr}, {31'd0, e.err});
               chk({e.name, "_rdata"}, ReadData, e.rdata);
            end
         end else if (MisalignErr) begin
            failures++;
            $display("FAIL err_without_ready actual=1 required=0");
         end
      end
   end

   initial begin
      logic [31:0] a, d;
      bit rd, wr;
      int w;
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, Ready}, 32'd0);
      chk("rst_busy", {31'd0, Busy}, 32'd0);
      chk("rst_err", {31'd0, MisalignErr}, 32'd0);
      chk("rst_rdata", ReadData, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < NWORDS; i++) do_req(0, 1, 32'(i * 4), $urandom, 3'b010, "init_sw");

      do_req(0, 1, 32'h10, 32'hDEAD_BEEF, 3'b010, "sw_deadbeef");
      do_req(1, 0, 32'h10, 32'h0, 3'b010, "lw_10");
      do_req(0, 1, 32'h13, 32'h0000_0080, 3'b000, "sb_13");
      do_req(1, 0, 32'h13, 32'h0, 3'b000, "lb_13");
      do_req(1, 0, 32'h13, 32'h0, 3'b100, "lbu_13");
      do_req(1, 0, 32'h10, 32'h0, 3'b010, "lw_10_merged");
      do_req(1, 0, 32'h11, 32'h0, 3'b001, "lh_11_misalign");
      do_req(0, 1, 32'h12, 32'h5555_AAAA, 3'b010, "sw_12_misalign");
      do_req(1, 0, 32'h10, 32'h0, 3'b010, "lw_10_unchanged");
      do_req(0, 1, (32'd4 << ADDR_W) + 32'h8, 32'h1234_5678, 3'b010, "sw_wrap");
      do_req(1, 0, 32'h8, 32'h0, 3'b010, "lw_wrap");
      do_req(1, 1, 32'h20, 32'hA5A5_5A5A, 3'b010, "both_high_store");
      do_req(1, 0, 32'h20, 32'h0, 3'b010, "lw_20");
      do_req(0, 1, 32'h24, 32'h1111_1111, 3'b100, "sbu_illegal");
      do_req(1, 0, 32'h24, 32'h0, 3'b011, "ld_illegal");
      do_req(1, 0, 32'h22, 32'h0, 3'b101, "lhu_22");

      // reset in the middle of a store's WAIT: store must be dropped
      @(negedge clk);
      MemWrite = 1'b1; Addr = 32'h10; WriteData = 32'hCAFE_F00D; Funct3 = 3'b010;
      @(negedge clk);
      chk("busy_in_wait", {31'd0, Busy}, 32'd1);
      rst_n = 1'b0;
      MemWrite = 1'b0;
      #1;
      chk("midrst_ready", {31'd0, Ready}, 32'd0);
      chk("midrst_busy", {31'd0, Busy}, 32'd0);
      chk("midrst_err", {31'd0, MisalignErr}, 32'd0);
      chk("midrst_rdata", ReadData, 32'd0);
      last_rd = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      do_req(1, 0, 32'h10, 32'h0, 3'b010, "lw_after_rst");

      for (int n = 0; n < 300; n++) begin
         w  = $urandom_range(0, NWORDS - 1);
         a  = ($urandom << (ADDR_W + 2)) | 32'(w << 2) | 32'($urandom_range(0, 3));
         d  = $urandom;
         wr = ($urandom_range(0, 2) == 0);
         rd = !wr || ($urandom_range(0, 4) == 0);
         do_req(rd, wr, a, d, 3'($urandom_range(0, 7)), "rand");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (WAIT_CYCLES + 4) @(negedge clk);
      if (q.size() != 0) begin
         checks++; failures++;
         $display("FAIL pending_responses actual=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
